// File: rtl/change_dispenser.sv
// Change dispenser: splits a change amount into 50/10/5/1 coins greedily
// against per-denomination inventories and feeds a hopper one coin at a time.
module change_dispenser #(
  parameter logic [7:0] INIT_CNT_50 = 8'd20,
  parameter logic [7:0] INIT_CNT_10 = 8'd20,
  parameter logic [7:0] INIT_CNT_5  = 8'd20,
  parameter logic [7:0] INIT_CNT_1  = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] exchange,
  input  logic       refill,
  input  logic       eject_ack,
  output logic       eject_valid,
  output logic [7:0] eject_coin,
  output logic       busy,
  output logic       done,
  output logic [7:0] short_amount,
  output logic       lost,
  output logic [7:0] cnt_50,
  output logic [7:0] cnt_10,
  output logic [7:0] cnt_5,
  output logic [7:0] cnt_1
);

  typedef enum logic [1:0] {
    IDLE, SELECT, EJECT, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] coin_q, coin_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       lost_q, lost_d;
  logic [7:0] short_q, short_d;
  logic [7:0] c50_q, c50_d;
  logic [7:0] c10_q, c10_d;
  logic [7:0] c5_q, c5_d;
  logic [7:0] c1_q, c1_d;
  logic       e50, e10, e5, e1;

  // Mutually exclusive eligibility flags encode the 50/10/5/1 priority
  always_comb begin
    e50 = (rem_q >= 8'd50) && (c50_q != 8'd0);
    e10 = !e50 && (rem_q >= 8'd10) && (c10_q != 8'd0);
    e5  = !e50 && !e10 && (rem_q >= 8'd5) && (c5_q != 8'd0);
    e1  = !e50 && !e10 && !e5 && (rem_q >= 8'd1) && (c1_q != 8'd0);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    lost_d  = (state_q != IDLE) && (exchange != 8'd0);
    short_d = short_q;
    c50_d   = c50_q;
    c10_d   = c10_q;
    c5_d    = c5_q;
    c1_d    = c1_q;
    unique case (state_q)
      IDLE: begin
        if (exchange != 8'd0) begin
          rem_d   = exchange;
          short_d = 8'd0;
          state_d = SELECT;
        end else if (refill) begin
          c50_d = INIT_CNT_50;
          c10_d = INIT_CNT_10;
          c5_d  = INIT_CNT_5;
          c1_d  = INIT_CNT_1;
        end
      end
      SELECT: begin
        unique case (1'b1)
          e50: begin
            coin_d = 8'd50; valid_d = 1'b1; state_d = EJECT;
          end
          e10: begin
            coin_d = 8'd10; valid_d = 1'b1; state_d = EJECT;
          end
          e5: begin
            coin_d = 8'd5; valid_d = 1'b1; state_d = EJECT;
          end
          e1: begin
            coin_d = 8'd1; valid_d = 1'b1; state_d = EJECT;
          end
          default: begin
            short_d = rem_q;
            done_d  = 1'b1;
            state_d = DONE;
          end
        endcase
      end
      EJECT: begin
        if (eject_ack) begin
          rem_d = rem_q - coin_q;
          unique case (coin_q)
            8'd50:   c50_d = c50_q - 8'd1;
            8'd10:   c10_d = c10_q - 8'd1;
            8'd5:    c5_d  = c5_q - 8'd1;
            default: c1_d  = c1_q - 8'd1;
          endcase
          valid_d = 1'b0;
          coin_d  = 8'd0;
          state_d = SELECT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      coin_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
      short_q <= 8'd0;
      c50_q   <= INIT_CNT_50;
      c10_q   <= INIT_CNT_10;
      c5_q    <= INIT_CNT_5;
      c1_q    <= INIT_CNT_1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
      short_q <= short_d;
      c50_q   <= c50_d;
      c10_q   <= c10_d;
      c5_q    <= c5_d;
      c1_q    <= c1_d;
    end
  end

  assign eject_valid  = valid_q;
  assign eject_coin   = coin_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign lost         = lost_q;
  assign short_amount = short_q;
  assign cnt_50       = c50_q;
  assign cnt_10       = c10_q;
  assign cnt_5        = c5_q;
  assign cnt_1        = c1_q;

endmodule
